// File: rtl/bcd_pkg.sv
// bcd_pkg -- shared constants and types for the BCD scan counter slice.
//   NUM_DIGITS   : number of decimal digits in the counter
//   DIGIT_W      : width of one BCD digit
//   BCD_MAX      : largest legal digit value
//   digit_t      : one BCD digit
//   bcdSanitize  : maps an illegal digit code (A..F) to 0
package bcd_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t BCD_MAX = 4'd9;

  function automatic digit_t bcdSanitize(input digit_t d);
    return (d > BCD_MAX) ? '0 : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit -- one decimal digit of an up/down ripple counter.
// Ports:
//   iClk, iRst_n : clock, asynchronous active-low reset
//   clr          : synchronous clear (highest priority)
//   load, loadVal: synchronous load; digit codes above 9 load as 0
//   up           : 1 = increment, 0 = decrement
//   carryIn      : step request from the lower digit (or the tick)
//   q            : current digit value
//   carryOut     : this digit wraps on the requested step
module bcd_digit
  import bcd_pkg::*;
(
  input  logic   iClk,
  input  logic   iRst_n,
  input  logic   clr,
  input  logic   load,
  input  digit_t loadVal,
  input  logic   up,
  input  logic   carryIn,
  output digit_t q,
  output logic   carryOut
);

  always_comb begin
    carryOut = 1'b0;
    if (carryIn) begin
      carryOut = up ? (q == BCD_MAX) : (q == '0);
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= bcdSanitize(loadVal);
    end else if (carryIn) begin
      if (up) begin
        q <= (q == BCD_MAX) ? '0 : q + DIGIT_W'(1);
      end else begin
        q <= (q == '0) ? BCD_MAX : q - DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter -- 4-digit BCD up/down counter with multiplexed display scan.
// Parameters:
//   COUNT_DIV : iClk cycles per count tick (>= 2)
//   SCAN_DIV  : iClk cycles per displayed digit slot (>= 2)
// Ports:
//   iClk, iRst_n : clock, asynchronous active-low reset
//   iEn          : count enable (0 freezes prescaler and count)
//   iUp          : 1 = count up, 0 = count down
//   iClr         : synchronous clear of count and prescaler
//   iLoad        : synchronous load of iLoadVal (BCD_SCAN_LOAD_EN builds only)
//   iLoadVal     : four BCD digits to load   (BCD_SCAN_LOAD_EN builds only)
//   oDigit       : registered BCD value of the scanned digit
//   oAn          : active-low one-hot anode select, one cycle behind oDigit
//   oCarry       : one-cycle pulse after a decimal wrap
// Build option: define BCD_SCAN_LOAD_EN to add the load ports.
module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int unsigned COUNT_DIV = 50000000,
  parameter int unsigned SCAN_DIV  = 50000
) (
  input  logic                              iClk,
  input  logic                              iRst_n,
  input  logic                              iEn,
  input  logic                              iUp,
  input  logic                              iClr,
`ifdef BCD_SCAN_LOAD_EN
  input  logic                              iLoad,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]     iLoadVal,
`endif
  output digit_t                            oDigit,
  output logic [NUM_DIGITS-1:0]             oAn,
  output logic                              oCarry
);

  localparam int unsigned PRESC_W = (COUNT_DIV > 2) ? $clog2(COUNT_DIV) : 1;
  localparam int unsigned SCAN_W  = (SCAN_DIV > 2)  ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(COUNT_DIV - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);

  logic                          load;
  logic [NUM_DIGITS*DIGIT_W-1:0] loadVal;

`ifdef BCD_SCAN_LOAD_EN
  assign load    = iLoad;
  assign loadVal = iLoadVal;
`else
  assign load    = 1'b0;
  assign loadVal = '0;
`endif

  // Count prescaler
  logic [PRESC_W-1:0] presc;
  logic               tick;

  assign tick = iEn && (presc == PRESC_LAST);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      presc <= '0;
    end else if (iClr || load) begin
      presc <= '0;
    end else if (iEn) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + PRESC_W'(1);
    end
  end

  // Ripple chain: the tick steps digit 0, each wrap steps the next digit.
  digit_t                digits [NUM_DIGITS];
  logic [NUM_DIGITS:0]   carry;

  assign carry[0] = tick;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gDigit
    bcd_digit uDigit (
      .iClk     (iClk),
      .iRst_n   (iRst_n),
      .clr      (iClr),
      .load     (load),
      .loadVal  (loadVal[g*DIGIT_W +: DIGIT_W]),
      .up       (iUp),
      .carryIn  (carry[g]),
      .q        (digits[g]),
      .carryOut (carry[g+1])
    );
  end

  // Clear and load suppress the step inside the digits, so they must also
  // suppress the wrap pulse even though the chain still reports a carry.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oCarry <= 1'b0;
    end else begin
      oCarry <= carry[NUM_DIGITS] && !iClr && !load;
    end
  end

  // Display scan, free-running
  logic [SCAN_W-1:0]     scanDiv;
  logic [IDX_W-1:0]      scanIdx;
  logic [NUM_DIGITS-1:0] anStage;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      scanDiv <= '0;
      scanIdx <= '0;
    end else if (scanDiv == SCAN_LAST) begin
      scanDiv <= '0;
      scanIdx <= scanIdx + IDX_W'(1);
    end else begin
      scanDiv <= scanDiv + SCAN_W'(1);
    end
  end

  // oDigit samples the live count every cycle so updates show without waiting
  // for the next slot; the anode gets one extra stage to match the decoder.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oDigit  <= '0;
      anStage <= '1;
      oAn     <= '1;
    end else begin
      oDigit  <= digits[scanIdx];
      anStage <= ~(NUM_DIGITS'(1) << scanIdx);
      oAn     <= anStage;
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter -- self-checking bench for bcd_scan_counter
// (COUNT_DIV = 2, SCAN_DIV = 2). Load scenarios build only with BCD_SCAN_LOAD_EN.
module tb_bcd_scan_counter;

  localparam int unsigned CD = 2;
  localparam int unsigned SD = 2;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic        iEn;
  logic        iUp;
  logic        iClr;
`ifdef BCD_SCAN_LOAD_EN
  logic        iLoad;
  logic [15:0] iLoadVal;
`endif
  logic [3:0]  oDigit;
  logic [3:0]  oAn;
  logic        oCarry;

  always #5 iClk = ~iClk;

  bcd_scan_counter #(
    .COUNT_DIV (CD),
    .SCAN_DIV  (SD)
  ) dut (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iEn      (iEn),
    .iUp      (iUp),
    .iClr     (iClr),
`ifdef BCD_SCAN_LOAD_EN
    .iLoad    (iLoad),
    .iLoadVal (iLoadVal),
`endif
    .oDigit   (oDigit),
    .oAn      (oAn),
    .oCarry   (oCarry)
  );

  int          checks = 0;
  int          errors = 0;
  int          mCnt   = 0;
  int          mPresc = 0;
  int          carrySeen = 0;
  logic [15:0] expQ [$];

  function automatic logic [15:0] toBcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  function automatic int fromLoad(input logic [15:0] v);
    int r;
    int scale;
    logic [3:0] d;
    r = 0;
    scale = 1;
    for (int k = 0; k < 4; k++) begin
      d = v[k*4 +: 4];
      if (d <= 4'd9) r = r + int'(d) * scale;
      scale = scale * 10;
    end
    return r;
  endfunction

  // One clock: update the reference model from the current inputs, advance,
  // then compare oCarry with the model's wrap prediction.
  task automatic cycle();
    logic        ld;
    logic [15:0] lv;
    logic        nextCarry;
`ifdef BCD_SCAN_LOAD_EN
    ld = iLoad;
    lv = iLoadVal;
`else
    ld = 1'b0;
    lv = '0;
`endif
    nextCarry = 1'b0;
    if (iClr) begin
      mCnt = 0;
      mPresc = 0;
    end else if (ld) begin
      mCnt = fromLoad(lv);
      mPresc = 0;
    end else if (iEn) begin
      if (mPresc == int'(CD) - 1) begin
        mPresc = 0;
        if (iUp) begin
          nextCarry = (mCnt == 9999);
          mCnt = (mCnt + 1) % 10000;
        end else begin
          nextCarry = (mCnt == 0);
          mCnt = (mCnt + 9999) % 10000;
        end
      end else begin
        mPresc++;
      end
    end
    @(posedge iClk);
    #1;
    if (oCarry === 1'b1) carrySeen++;
    checks++;
    if (oCarry !== nextCarry) begin
      errors++;
      $display("FAIL carry: got %b expected %b at %0t", oCarry, nextCarry, $time);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Freeze the count and reassemble it from the display: the anode seen in
  // one sample names the digit shown on oDigit in the sample before.
  task automatic readCount(output logic [15:0] v, output logic [3:0] seen);
    logic [3:0] prevDigit;
    logic       prevValid;
    iEn = 1'b0;
    iClr = 1'b0;
    v = '0;
    seen = '0;
    prevDigit = '0;
    prevValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (prevValid) begin
        case (oAn)
          4'b1110: begin v[3:0]   = prevDigit; seen[0] = 1'b1; end
          4'b1101: begin v[7:4]   = prevDigit; seen[1] = 1'b1; end
          4'b1011: begin v[11:8]  = prevDigit; seen[2] = 1'b1; end
          4'b0111: begin v[15:12] = prevDigit; seen[3] = 1'b1; end
          default: ;
        endcase
      end
      prevDigit = oDigit;
      prevValid = 1'b1;
    end
  endtask

  task automatic clearCount();
    iEn = 1'b0;
    iClr = 1'b1;
    cycle();
    iClr = 1'b0;
  endtask

  task automatic test_reset();
    iRst_n = 1'b0;
    iEn = 1'b0;
    iUp = 1'b1;
    iClr = 1'b0;
`ifdef BCD_SCAN_LOAD_EN
    iLoad = 1'b0;
    iLoadVal = '0;
`endif
    repeat (3) @(posedge iClk);
    #1;
    checks++;
    if (oAn !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b expected 1111", oAn); end
    checks++;
    if (oDigit !== 4'd0) begin errors++; $display("FAIL reset_digit: got %h expected 0", oDigit); end
    checks++;
    if (oCarry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", oCarry); end
    iRst_n = 1'b1;
    mCnt = 0;
    mPresc = 0;
  endtask

  task automatic test_count_up();
    logic [15:0] v, e;
    logic [3:0]  seen;
    iUp = 1'b1;
    iEn = 1'b1;
    carrySeen = 0;
    expQ.push_back(16'h0010);
    run(20);
    readCount(v, seen);
    e = expQ.pop_front();
    checks++;
    if (seen !== 4'hF || v !== e) begin
      errors++;
      $display("FAIL count_up: got %h (seen %b) expected %h", v, seen, e);
    end
    checks++;
    if (carrySeen !== 0) begin errors++; $display("FAIL count_up_carry: got %0d pulses expected 0", carrySeen); end
  endtask

  task automatic test_down_wrap();
    logic [15:0] v, e;
    logic [3:0]  seen;
    clearCount();
    carrySeen = 0;
    iUp = 1'b0;
    iEn = 1'b1;
    expQ.push_back(16'h9999);
    run(CD);
    readCount(v, seen);
    e = expQ.pop_front();
    checks++;
    if (seen !== 4'hF || v !== e) begin
      errors++;
      $display("FAIL down_wrap: got %h (seen %b) expected %h", v, seen, e);
    end
    checks++;
    if (carrySeen !== 1) begin errors++; $display("FAIL down_wrap_carry: got %0d pulses expected 1", carrySeen); end
    iEn = 1'b1;
    expQ.push_back(16'h9998);
    run(CD);
    readCount(v, seen);
    e = expQ.pop_front();
    checks++;
    if (seen !== 4'hF || v !== e) begin
      errors++;
      $display("FAIL down_step: got %h (seen %b) expected %h", v, seen, e);
    end
  endtask

  // Continues from 9998 left by test_down_wrap.
  task automatic test_up_wrap();
    logic [15:0] v, e;
    logic [3:0]  seen;
    carrySeen = 0;
    iUp = 1'b1;
    iEn = 1'b1;
    expQ.push_back(16'h9999);
    run(CD);
    readCount(v, seen);
    e = expQ.pop_front();
    checks++;
    if (seen !== 4'hF || v !== e) begin
      errors++;
      $display("FAIL up_pre_wrap: got %h (seen %b) expected %h", v, seen, e);
    end
    checks++;
    if (carrySeen !== 0) begin errors++; $display("FAIL up_pre_wrap_carry: got %0d pulses expected 0", carrySeen); end
    iEn = 1'b1;
    expQ.push_back(16'h0000);
    run(CD);
    readCount(v, seen);
    e = expQ.pop_front();
    checks++;
    if (seen !== 4'hF || v !== e) begin
      errors++;
      $display("FAIL up_wrap: got %h (seen %b) expected %h", v, seen, e);
    end
    checks++;
    if (carrySeen !== 1) begin errors++; $display("FAIL up_wrap_carry: got %0d pulses expected 1", carrySeen); end
  endtask

  task automatic test_clr_priority();
    logic [15:0] v, e;
    logic [3:0]  seen;
    clearCount();
    iUp = 1'b0;
    iEn = 1'b1;
    run(CD);
    iUp = 1'b1;
    // Advance to the cycle where the prescaler would tick (9999 -> wrap).
    run(CD - 1);
    carrySeen = 0;
    iClr = 1'b1;
`ifdef BCD_SCAN_LOAD_EN
    iLoad = 1'b1;
    iLoadVal = 16'h1234;
`endif
    cycle();
    iClr = 1'b0;
    iEn = 1'b0;
`ifdef BCD_SCAN_LOAD_EN
    iLoad = 1'b0;
`endif
    expQ.push_back(16'h0000);
    readCount(v, seen);
    e = expQ.pop_front();
    checks++;
    if (seen !== 4'hF || v !== e) begin
      errors++;
      $display("FAIL clr_priority: got %h (seen %b) expected %h", v, seen, e);
    end
    checks++;
    if (carrySeen !== 0) begin errors++; $display("FAIL clr_carry: got %0d pulses expected 0", carrySeen); end
  endtask

  task automatic test_scan();
    logic [15:0] e;
    logic [3:0]  prevDigit;
    int          lastIdx;
    int          idx;
    int          slots;
    clearCount();
    iUp = 1'b1;
    iEn = 1'b1;
    run(1234 * CD);
    iEn = 1'b0;
    expQ.push_back(16'h1234);
    e = expQ.pop_front();
    cycle();
    prevDigit = oDigit;
    lastIdx = -1;
    slots = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      case (oAn)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      checks++;
      if (idx < 0) begin
        errors++;
        $display("FAIL scan_an: got %b expected one-hot low", oAn);
      end else begin
        if (prevDigit !== e[idx*4 +: 4]) begin
          errors++;
          $display("FAIL scan_digit: got %h expected %h for anode %b", prevDigit, e[idx*4 +: 4], oAn);
        end
        if (lastIdx >= 0 && idx != lastIdx) begin
          slots++;
          checks++;
          if (idx != (lastIdx + 1) % 4) begin
            errors++;
            $display("FAIL scan_order: got digit %0d expected %0d", idx, (lastIdx + 1) % 4);
          end
        end
        lastIdx = idx;
      end
      prevDigit = oDigit;
    end
    checks++;
    if (slots < 8) begin errors++; $display("FAIL scan_advance: got %0d slot changes expected >= 8", slots); end
  endtask

  // Runs with count 1234, so every digit shown is non-zero before reset.
  task automatic test_async_reset();
    logic [15:0] v, e;
    logic [3:0]  seen;
    iEn = 1'b1;
    iUp = 1'b1;
    cycle();
    checks++;
    if (oDigit === 4'd0) begin errors++; $display("FAIL pre_reset_digit: got %h expected non-zero", oDigit); end
    #3;
    iRst_n = 1'b0;
    #1;
    checks++;
    if (oAn !== 4'b1111) begin errors++; $display("FAIL async_an: got %b expected 1111", oAn); end
    checks++;
    if (oDigit !== 4'd0) begin errors++; $display("FAIL async_digit: got %h expected 0", oDigit); end
    checks++;
    if (oCarry !== 1'b0) begin errors++; $display("FAIL async_carry: got %b expected 0", oCarry); end
    @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    mCnt = 0;
    mPresc = 0;
    iEn = 1'b1;
    expQ.push_back(16'h0000);
    run(CD - 1);
    readCount(v, seen);
    e = expQ.pop_front();
    checks++;
    if (seen !== 4'hF || v !== e) begin
      errors++;
      $display("FAIL first_tick_early: got %h (seen %b) expected %h", v, seen, e);
    end
    iEn = 1'b1;
    expQ.push_back(16'h0001);
    run(1);
    readCount(v, seen);
    e = expQ.pop_front();
    checks++;
    if (seen !== 4'hF || v !== e) begin
      errors++;
      $display("FAIL first_tick: got %h (seen %b) expected %h", v, seen, e);
    end
  endtask

`ifdef BCD_SCAN_LOAD_EN
  task automatic test_load();
    logic [15:0] v, e;
    logic [3:0]  seen;
    iEn = 1'b1;
    iUp = 1'b1;
    iLoad = 1'b1;
    iLoadVal = 16'hA5F3;
    cycle();
    iLoad = 1'b0;
    iEn = 1'b0;
    expQ.push_back(16'h0503);
    run(10);
    readCount(v, seen);
    e = expQ.pop_front();
    checks++;
    if (seen !== 4'hF || v !== e) begin
      errors++;
      $display("FAIL load_sanitize: got %h (seen %b) expected %h", v, seen, e);
    end
    iLoad = 1'b1;
    iLoadVal = 16'h9998;
    cycle();
    iLoad = 1'b0;
    carrySeen = 0;
    iEn = 1'b1;
    expQ.push_back(16'h0000);
    run(2 * CD);
    readCount(v, seen);
    e = expQ.pop_front();
    checks++;
    if (seen !== 4'hF || v !== e) begin
      errors++;
      $display("FAIL load_wrap: got %h (seen %b) expected %h", v, seen, e);
    end
    checks++;
    if (carrySeen !== 1) begin errors++; $display("FAIL load_wrap_carry: got %0d pulses expected 1", carrySeen); end
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_down_wrap();
    test_up_wrap();
    test_clr_priority();
    test_scan();
    test_async_reset();
`ifdef BCD_SCAN_LOAD_EN
    test_load();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 Parameter COUNT_DIV, default 50000000: iClk cycles per count tick; legal minimum 2.
REQ-002 Parameter SCAN_DIV, default 50000: iClk cycles per displayed digit slot; legal minimum 2.
REQ-003 Clocking and reset SHALL be one clock, iClk; reset iRst_n, asynchronous, active-low.
REQ-004 iClk  input  1  system clock, all state on rising edge.
REQ-005 iRst_n  input  1  asynchronous active-low reset.
REQ-006 iEn  input  1  count enable; 0 freezes the prescaler and the count value.
REQ-007 iUp  input  1  direction, 1 = increment, 0 = decrement.
REQ-008 iClr  input  1  synchronous clear of count and prescaler.
REQ-009 oDigit  output  4  BCD value of the currently scanned digit, feeds the 7-segment decoder input.
REQ-010 oAn  output  4  digit select, one-hot active-low, bit k = digit k (0 = units).
REQ-011 oCarry  output  1  one-cycle pulse on decimal wrap (9999->0000 up, 0000->9999 down).

Function
REQ-012 The prescaler SHALL count 0..COUNT_DIV-1 only while iEn=1, hold while iEn=0, and generate a tick in the cycle it is at COUNT_DIV-1 (then return to 0).
REQ-013 On a tick with iUp=1, the 4-digit BCD value SHALL increment with decimal carry, each digit staying within 0..9.
REQ-014 On a tick with iUp=0, the value SHALL decrement with decimal borrow (e.g. 0100->0099).
REQ-015 Wrap 9999->0000 (up) or 0000->9999 (down) SHALL assert oCarry for exactly the cycle after the wrapping tick; oCarry SHALL be 0 otherwise.
REQ-016 iClr=1 SHALL, on the next edge, set all digits to 0 and the prescaler to 0, taking priority over a coincident tick or load; no oCarry pulse results.
REQ-017 A change of iUp SHALL take effect at the next tick; no partial-step behaviour.
REQ-018 The scan counter SHALL run continuously (independent of iEn/iClr), advancing the digit index 0->1->2->3->0 every SCAN_DIV cycles.
REQ-019 oDigit SHALL be registered and equal the count digit selected by the scan index one cycle earlier.
REQ-020 The downstream decoder adds one register stage, so oAn SHALL be delayed one further cycle relative to oDigit, keeping the anode aligned with the decoded segments.
REQ-021 A count update while a digit is displayed SHALL appear on oDigit within one cycle, without waiting for the next scan slot.

Reset
REQ-022 While iRst_n=0: digits 0000, prescaler 0, scan index 0, scan divider 0, oDigit 4'b0000, oAn 4'b1111 (all off), oCarry 0.
REQ-023 Reset assertion mid-count or mid-scan SHALL clear immediately (asynchronous); after deassertion, the first tick SHALL occur COUNT_DIV cycles later with iEn=1.

Configuration
REQ-024 Macro BCD_SCAN_LOAD_EN SHALL, when defined, add ports iLoad (input 1) and iLoadVal (input 16, four BCD digits).
REQ-025 With BCD_SCAN_LOAD_EN: iLoad=1 SHALL load iLoadVal on the next edge, force any digit above 9 to 0, reset the prescaler, and take priority over a tick but not over iClr.
REQ-026 Without BCD_SCAN_LOAD_EN: the ports are absent and the count SHALL change only by tick, clear, or reset.

Structure
REQ-027 The shared package bcd_pkg SHALL hold NUM_DIGITS=4, DIGIT_W=4, BCD_MAX=4'd9, and the 4-bit digit typedef.
REQ-028 Sub-module bcd_digit (one-digit up/down counter with carry-in/carry-out) SHALL be instantiated NUM_DIGITS times in a ripple chain.

Verification (COUNT_DIV=2, SCAN_DIV=2 unless stated)
REQ-029 Reset, then iEn=1, iUp=1 for 20 cycles -> count 0010; oCarry never asserted.
REQ-030 Count preset to 9998 via load, up, two ticks -> 9999 then 0000; oCarry high exactly 1 cycle after the second tick.
REQ-031 Count 0000, iUp=0, one tick -> 9999, oCarry pulses once; a following tick -> 9998.
REQ-032 Count 1234, observe scan -> oDigit cycles 4,3,2,1; each oAn value (1110,1101,1011,0111) follows its oDigit by exactly 1 cycle.
REQ-033 iClr coincident with a tick and with iLoad -> count 0000, no oCarry pulse; iRst_n pulsed low mid-scan -> oAn 1111 and oDigit 0 within the same cycle.
REQ-034 Load iLoadVal=16'hA5F3 -> count 0503; iEn=0 for 10 cycles -> value unchanged.
